crc_step_engine: RTL and testbench



---
 rtl/crc_step_engine.sv | 147 ++++++++++++++
 tb/tb_crc_step_engine.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/crc_step_engine.sv
// Word-oriented CRC-16/CRC-32 engine: one data word per operation, folded over
// four shift cycles, with optional input/output bit reversal and final XOR.
module crc_step_engine (
  input  logic        pclk,
  input  logic        prst,
  input  logic [1:0]  mode_i,
  input  logic        revin_i,
  input  logic        revout_i,
  input  logic [31:0] xorv_i,
  input  logic [31:0] init_i,
  input  logic        clr_i,
  input  logic        start_i,
  input  logic [31:0] data_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] crc_o,
  output logic [31:0] res_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_SHIFT1, S_SHIFT2, S_SHIFT3, S_SHIFT4, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  mode_q;
  logic        revout_q;
  logic [31:0] data_q;
  logic [31:0] crc_q;
  logic [31:0] res_q;
  logic        done_q;
  logic        w32_q;
  logic [7:0]  chunk;

  function automatic logic is_w32(input logic [1:0] m);
    return (m == 2'd2);
  endfunction

  function automatic logic [31:0] width_mask(input logic [1:0] m);
    return is_w32(m) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
  endfunction

  function automatic logic [31:0] rev_bytes(input logic [31:0] v);
    logic [31:0] r;
    r = '0;
    for (int b = 0; b < 4; b++)
      for (int i = 0; i < 8; i++)
        r[8*b+i] = v[8*b+7-i];
    return r;
  endfunction

  function automatic logic [31:0] rev_width(input logic [31:0] v, input logic w32);
    logic [31:0] r;
    r = '0;
    if (w32) begin
      for (int i = 0; i < 32; i++) r[i] = v[31-i];
    end else begin
      for (int i = 0; i < 16; i++) r[i] = v[15-i];
    end
    return r;
  endfunction

  // Unrolled MSB-first bit steps; the state is re-masked first so a mode
  // change without clr still yields a width-consistent state.
  function automatic logic [31:0] crc_chunk(input logic [31:0] crc,
                                            input logic [7:0]  chk,
                                            input logic [1:0]  m);
    logic [31:0] c;
    logic [31:0] poly;
    logic        fb;
    c = crc & width_mask(m);
    if (is_w32(m)) begin
      for (int i = 7; i >= 0; i--) begin
        fb = c[31] ^ chk[i];
        c  = {c[30:0], 1'b0} ^ (fb ? 32'h04C1_1DB7 : 32'h0);
      end
    end else begin
      poly = (m == 2'd1) ? 32'h0000_8005 : 32'h0000_1021;
      for (int i = 3; i >= 0; i--) begin
        fb = c[15] ^ chk[i];
        c  = ({c[30:0], 1'b0} ^ (fb ? poly : 32'h0)) & 32'h0000_FFFF;
      end
    end
    return c;
  endfunction

  assign w32_q = is_w32(mode_q);

  always_comb begin
    chunk = 8'h00;
    case (state_q)
      S_SHIFT1: chunk = w32_q ? data_q[31:24] : {4'h0, data_q[15:12]};
      S_SHIFT2: chunk = w32_q ? data_q[23:16] : {4'h0, data_q[11:8]};
      S_SHIFT3: chunk = w32_q ? data_q[15:8]  : {4'h0, data_q[7:4]};
      S_SHIFT4: chunk = w32_q ? data_q[7:0]   : {4'h0, data_q[3:0]};
      default:  chunk = 8'h00;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start_i) state_d = S_SHIFT1;
      S_SHIFT1: state_d = S_SHIFT2;
      S_SHIFT2: state_d = S_SHIFT3;
      S_SHIFT3: state_d = S_SHIFT4;
      S_SHIFT4: state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (prst) begin
      state_q  <= S_IDLE;
      mode_q   <= 2'd0;
      revout_q <= 1'b0;
      data_q   <= '0;
      crc_q    <= '0;
      res_q    <= '0;
      done_q   <= 1'b0;
    end else if (clr_i) begin
      // clr aborts everything; masking follows the live mode input
      state_q <= S_IDLE;
      crc_q   <= init_i & width_mask(mode_i);
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == S_DONE);
      if (state_q == S_IDLE && start_i) begin
        mode_q   <= mode_i;
        revout_q <= revout_i;
        data_q   <= revin_i ? rev_bytes(data_i) : data_i;
      end
      if (state_q inside {S_SHIFT1, S_SHIFT2, S_SHIFT3, S_SHIFT4})
        crc_q <= crc_chunk(crc_q, chunk, mode_q);
      if (state_q == S_DONE)
        res_q <= ((revout_q ? rev_width(crc_q, w32_q) : crc_q) ^ xorv_i)
                 & width_mask(mode_q);
    end
  end

  assign busy_o = (state_q != S_IDLE);
  assign done_o = done_q;
  assign crc_o  = crc_q;
  assign res_o  = res_q;

endmodule

// File: tb/tb_crc_step_engine.sv
// Directed bench for crc_step_engine: hand-computed CRC results, latency,
// clr/prst abort behaviour and start-while-busy rejection.
module tb_crc_step_engine;

  logic        pclk = 1'b0;
  logic        prst;
  logic [1:0]  mode_i;
  logic        revin_i;
  logic        revout_i;
  logic [31:0] xorv_i;
  logic [31:0] init_i;
  logic        clr_i;
  logic        start_i;
  logic [31:0] data_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] crc_o;
  logic [31:0] res_o;

  int vectors     = 0;
  int miscompares = 0;
  int done_cnt;

  crc_step_engine dut (
    .pclk    (pclk),
    .prst    (prst),
    .mode_i  (mode_i),
    .revin_i (revin_i),
    .revout_i(revout_i),
    .xorv_i  (xorv_i),
    .init_i  (init_i),
    .clr_i   (clr_i),
    .start_i (start_i),
    .data_i  (data_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .crc_o   (crc_o),
    .res_o   (res_o)
  );

  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic do_clr(input logic [1:0] m, input logic [31:0] v, input logic [31:0] exp);
    @(negedge pclk);
    mode_i = m; init_i = v; clr_i = 1'b1;
    @(posedge pclk);
    @(negedge pclk);
    clr_i = 1'b0;
    check("clr_crc", crc_o, exp);
  endtask

  task automatic start_op(input logic [1:0] m, input logic [31:0] d, input logic ri,
                          input logic ro, input logic [31:0] xv);
    @(negedge pclk);
    mode_i = m; data_i = d; revin_i = ri; revout_i = ro; xorv_i = xv; start_i = 1'b1;
    @(posedge pclk);
    #1 start_i = 1'b0;
  endtask

  task automatic do_op(input string tag, input logic [1:0] m, input logic [31:0] d,
                       input logic ri, input logic ro, input logic [31:0] xv,
                       input logic [31:0] exp_crc, input logic [31:0] exp_res);
    start_op(m, d, ri, ro, xv);
    repeat (4) @(posedge pclk);
    @(negedge pclk);
    check({tag, "_busy_n4"}, {31'b0, busy_o}, 32'd1);
    check({tag, "_done_n4"}, {31'b0, done_o}, 32'd0);
    check({tag, "_crc_n4"}, crc_o, exp_crc);
    @(posedge pclk);
    @(negedge pclk);
    check({tag, "_done_n5"}, {31'b0, done_o}, 32'd1);
    check({tag, "_res"}, res_o, exp_res);
    check({tag, "_busy_n5"}, {31'b0, busy_o}, 32'd0);
    @(posedge pclk);
    @(negedge pclk);
    check({tag, "_done_n6"}, {31'b0, done_o}, 32'd0);
  endtask

  task automatic count_done(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge pclk);
      @(negedge pclk);
      if (done_o) cnt++;
    end
  endtask

  initial begin
    prst = 1'b1; mode_i = 2'd0; revin_i = 1'b0; revout_i = 1'b0;
    xorv_i = '0; init_i = '0; clr_i = 1'b0; start_i = 1'b0; data_i = '0;
    repeat (2) @(posedge pclk);
    @(negedge pclk);
    prst = 1'b0;
    check("rst_busy", {31'b0, busy_o}, 32'd0);
    check("rst_done", {31'b0, done_o}, 32'd0);
    check("rst_crc", crc_o, 32'h0);
    check("rst_res", res_o, 32'h0);

    // CRC16-1021 basics and chaining
    do_clr(2'd0, 32'h0, 32'h0);
    do_op("m0_d1", 2'd0, 32'h0001, 1'b0, 1'b0, 32'h0, 32'h1021, 32'h1021);
    do_clr(2'd0, 32'h0, 32'h0);
    do_op("m0_d2", 2'd0, 32'h0002, 1'b0, 1'b0, 32'h0, 32'h2042, 32'h2042);
    do_op("m0_chain", 2'd0, 32'h2042, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);

    // CRC16-8005
    do_clr(2'd1, 32'h0, 32'h0);
    do_op("m1_d1", 2'd1, 32'h0001, 1'b0, 1'b0, 32'h0, 32'h8005, 32'h8005);
    do_clr(2'd1, 32'h0, 32'h0);
    do_op("m1_d2", 2'd1, 32'h0002, 1'b0, 1'b0, 32'h0, 32'h800F, 32'h800F);

    // CRC32
    do_clr(2'd2, 32'h0, 32'h0);
    do_op("m2_d1", 2'd2, 32'h0000_0001, 1'b0, 1'b0, 32'h0, 32'h04C1_1DB7, 32'h04C1_1DB7);
    do_op("m2_chain", 2'd2, 32'h04C1_1DB7, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);

    // Reversal and final XOR (upper XOR bits must be ignored in 16-bit mode)
    do_clr(2'd0, 32'h0, 32'h0);
    do_op("revin", 2'd0, 32'h0080, 1'b1, 1'b0, 32'h0, 32'h1021, 32'h1021);
    do_clr(2'd0, 32'h0, 32'h0);
    do_op("revout", 2'd0, 32'h0001, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h1021, 32'h7BF7);

    // Reserved mode behaves as CRC16-1021
    do_clr(2'd3, 32'h0, 32'h0);
    do_op("m3_d1", 2'd3, 32'h0001, 1'b0, 1'b0, 32'h0, 32'h1021, 32'h1021);

    // Init masking and nonzero init feeding the computation
    do_clr(2'd0, 32'hABCD_1234, 32'h1234);
    do_op("init_chain", 2'd0, 32'h1234, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    do_clr(2'd2, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

    // clr in SHIFT2 aborts: no done, state = init, res untouched
    do_clr(2'd0, 32'h0, 32'h0);
    start_op(2'd0, 32'h0001, 1'b0, 1'b0, 32'h0);
    @(posedge pclk);
    @(negedge pclk);
    clr_i = 1'b1; init_i = 32'h5555;
    @(posedge pclk);
    @(negedge pclk);
    clr_i = 1'b0;
    check("abort_busy", {31'b0, busy_o}, 32'd0);
    check("abort_crc", crc_o, 32'h5555);
    count_done(8, done_cnt);
    check("abort_no_done", done_cnt, 32'd0);
    check("abort_crc_hold", crc_o, 32'h5555);
    check("abort_res_hold", res_o, 32'h0);

    // start while busy is ignored
    do_clr(2'd0, 32'h0, 32'h0);
    start_op(2'd0, 32'h0001, 1'b0, 1'b0, 32'h0);
    @(posedge pclk);
    @(negedge pclk);
    start_i = 1'b1; data_i = 32'hFFFF;
    @(posedge pclk);
    #1 start_i = 1'b0; data_i = 32'h0;
    count_done(10, done_cnt);
    check("busy_start_done_cnt", done_cnt, 32'd1);
    check("busy_start_res", res_o, 32'h1021);
    check("busy_start_crc", crc_o, 32'h1021);

    // prst mid-operation returns all outputs to reset values
    start_op(2'd0, 32'h0002, 1'b0, 1'b0, 32'h0);
    @(posedge pclk);
    @(negedge pclk);
    prst = 1'b1;
    @(posedge pclk);
    @(negedge pclk);
    prst = 1'b0;
    check("prst_busy", {31'b0, busy_o}, 32'd0);
    check("prst_done", {31'b0, done_o}, 32'd0);
    check("prst_crc", crc_o, 32'h0);
    check("prst_res", res_o, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
